// File: rtl/rv32_wb_arbiter_if.sv
// rv32_wb_arbiter_if: producer handshakes and regfile write port of the write-back arbiter
interface rv32_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [AW-1:0]   req0_rd_i;
    logic [XLEN-1:0] req0_val_i;
    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [AW-1:0]   req1_rd_i;
    logic [XLEN-1:0] req1_val_i;
    logic            rf_we_o;
    logic [AW-1:0]   rf_rd_addr_o;
    logic [XLEN-1:0] rf_rd_val_o;
    modport slave (
        input  req0_valid_i, req0_rd_i, req0_val_i, req1_valid_i, req1_rd_i, req1_val_i,
        output req0_ready_o, req1_ready_o, rf_we_o, rf_rd_addr_o, rf_rd_val_o
    );
    modport master (
        output req0_valid_i, req0_rd_i, req0_val_i, req1_valid_i, req1_rd_i, req1_val_i,
        input  req0_ready_o, req1_ready_o, rf_we_o, rf_rd_addr_o, rf_rd_val_o
    );
endinterface

// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter: round-robin write-back arbiter and RAW scoreboard for the regfile write port
// Defining WB_BYPASS_EN forwards the in-flight write to the operand checks.
module rv32_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rv32_wb_arbiter_if.slave wb,
    input  logic             issue_valid_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic [AW-1:0]    chk_rs1_i,
    input  logic [AW-1:0]    chk_rs2_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o,
    output logic [NREG-1:0]  busy_o,
    output logic             err_o,
`ifdef WB_BYPASS_EN
    output logic             byp_rs1_hit_o,
    output logic             byp_rs2_hit_o,
    output logic [XLEN-1:0]  byp_rs1_val_o,
    output logic [XLEN-1:0]  byp_rs2_val_o,
`endif
    output logic             idle_o
);
    logic            last_q, we_q, err_q, err_d;
    logic [AW-1:0]   addr_q, xfer_rd;
    logic [XLEN-1:0] val_q, xfer_val;
    logic [NREG-1:0] busy_q, busy_d, set_v, clr_v;
    logic            gnt0, gnt1, xfer;
    always_comb begin
        gnt0     = ~rst_i & wb.req0_valid_i & (~wb.req1_valid_i | last_q);
        gnt1     = ~rst_i & wb.req1_valid_i & (~wb.req0_valid_i | ~last_q);
        xfer     = gnt0 | gnt1;
        xfer_rd  = gnt1 ? wb.req1_rd_i : wb.req0_rd_i;
        xfer_val = gnt1 ? wb.req1_val_i : wb.req0_val_i;
        set_v    = (issue_valid_i && issue_rd_i != '0) ? NREG'(1) << issue_rd_i : '0;
        clr_v    = we_q ? NREG'(1) << addr_q : '0;
        err_d    = err_q | (|(set_v & busy_q & ~clr_v));
        busy_d   = (busy_q & ~clr_v) | set_v;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= '0;
            val_q  <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= xfer ? gnt1 : last_q;
            we_q   <= xfer && xfer_rd != '0;
            addr_q <= xfer ? xfer_rd : addr_q;
            val_q  <= xfer ? xfer_val : val_q;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end
    assign wb.req0_ready_o = gnt0;
    assign wb.req1_ready_o = gnt1;
    assign wb.rf_we_o      = we_q;
    assign wb.rf_rd_addr_o = addr_q;
    assign wb.rf_rd_val_o  = val_q;
    assign busy_o          = busy_q;
    assign err_o           = err_q;
    assign idle_o          = busy_q == '0 && !we_q;
`ifdef WB_BYPASS_EN
    assign byp_rs1_hit_o = we_q && addr_q == chk_rs1_i && chk_rs1_i != '0;
    assign byp_rs2_hit_o = we_q && addr_q == chk_rs2_i && chk_rs2_i != '0;
    assign byp_rs1_val_o = byp_rs1_hit_o ? val_q : '0;
    assign byp_rs2_val_o = byp_rs2_hit_o ? val_q : '0;
    assign rs1_busy_o    = busy_q[chk_rs1_i] & ~byp_rs1_hit_o;
    assign rs2_busy_o    = busy_q[chk_rs2_i] & ~byp_rs2_hit_o;
`else
    assign rs1_busy_o = busy_q[chk_rs1_i];
    assign rs2_busy_o = busy_q[chk_rs2_i];
`endif
endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// tb_rv32_wb_arbiter: scoreboard bench with directed and random traffic against a reference model
module tb_rv32_wb_arbiter;
    localparam int XLEN = 32, NREG = 32, AW = 5;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    rv32_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) wb();
    logic            issue_valid = 1'b0;
    logic [AW-1:0]   issue_rd = '0, chk1 = '0, chk2 = '0;
    logic            rs1_busy, rs2_busy, err, idle;
    logic [NREG-1:0] busy;
`ifdef WB_BYPASS_EN
    logic            h1, h2;
    logic [XLEN-1:0] bv1, bv2;
`endif
    rv32_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .wb(wb),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .chk_rs1_i(chk1), .chk_rs2_i(chk2),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .busy_o(busy), .err_o(err),
`ifdef WB_BYPASS_EN
        .byp_rs1_hit_o(h1), .byp_rs2_hit_o(h2), .byp_rs1_val_o(bv1), .byp_rs2_val_o(bv2),
`endif
        .idle_o(idle)
    );
    typedef struct {int due; logic [AW-1:0] a; logic [XLEN-1:0] d;} wr_t;
    wr_t             q[$];
    int              cyc = 0, tests = 0, fails = 0, last_m = 1;
    logic [NREG-1:0] busy_m = '0;
    bit              err_m = 0, cw_v = 0;
    logic [AW-1:0]   cw_a = '0;
    logic [XLEN-1:0] cw_d = '0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask
    // Each expected write is due in exactly one cycle; any other cycle must have rf_we_o low.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rf_we", wb.rf_we_o, 1);
            chk("rf_addr", wb.rf_rd_addr_o, q[0].a);
            chk("rf_val", wb.rf_rd_val_o, q[0].d);
            void'(q.pop_front());
        end else chk("rf_we_idle", wb.rf_we_o, 0);
    end
    task automatic step();
        int win;
        bit hit1, hit2, nv;
        logic [AW-1:0] a;
        logic [XLEN-1:0] d;
        @(negedge clk);
        win = -1;
        if (!rst) begin
            if (wb.req0_valid_i && wb.req1_valid_i) win = 1 - last_m;
            else if (wb.req0_valid_i) win = 0;
            else if (wb.req1_valid_i) win = 1;
        end
`ifdef WB_BYPASS_EN
        hit1 = cw_v && cw_a == chk1 && chk1 != 0;
        hit2 = cw_v && cw_a == chk2 && chk2 != 0;
        chk("byp_rs1_hit", h1, hit1);
        chk("byp_rs2_hit", h2, hit2);
        chk("byp_rs1_val", bv1, hit1 ? cw_d : 0);
        chk("byp_rs2_val", bv2, hit2 ? cw_d : 0);
`else
        hit1 = 0;
        hit2 = 0;
`endif
        chk("req0_ready", wb.req0_ready_o, win == 0);
        chk("req1_ready", wb.req1_ready_o, win == 1);
        chk("busy_o", busy, busy_m);
        chk("err_o", err, err_m);
        chk("idle_o", idle, busy_m == 0 && !cw_v);
        chk("rs1_busy", rs1_busy, busy_m[chk1] && !hit1);
        chk("rs2_busy", rs2_busy, busy_m[chk2] && !hit2);
        nv = 0;
        a = '0;
        d = '0;
        if (rst) begin
            busy_m = '0;
            err_m = 0;
            last_m = 1;
        end else begin
            if (issue_valid && issue_rd != 0 && busy_m[issue_rd] && !(cw_v && cw_a == issue_rd)) err_m = 1;
            if (cw_v) busy_m[cw_a] = 1'b0;
            if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
            if (win >= 0) begin
                last_m = win;
                a = win == 1 ? wb.req1_rd_i : wb.req0_rd_i;
                d = win == 1 ? wb.req1_val_i : wb.req0_val_i;
                if (a != 0) begin
                    q.push_back(wr_t'{due: cyc + 1, a: a, d: d});
                    nv = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cw_v = nv;
        if (nv) begin
            cw_a = a;
            cw_d = d;
        end
        if (win == 0) wb.req0_valid_i = 1'b0;
        if (win == 1) wb.req1_valid_i = 1'b0;
        issue_valid = 1'b0;
    endtask
    task automatic req0(input logic [AW-1:0] r, input logic [XLEN-1:0] v);
        wb.req0_valid_i = 1'b1; wb.req0_rd_i = r; wb.req0_val_i = v;
    endtask
    task automatic req1(input logic [AW-1:0] r, input logic [XLEN-1:0] v);
        wb.req1_valid_i = 1'b1; wb.req1_rd_i = r; wb.req1_val_i = v;
    endtask
    task automatic issue(input logic [AW-1:0] r);
        issue_valid = 1'b1; issue_rd = r;
    endtask
    initial begin
        wb.req1_valid_i = 1'b0; wb.req1_rd_i = '0; wb.req1_val_i = '0;
        req0(1, 32'h11);
        step(); step();
        wb.req0_valid_i = 1'b0; rst = 1'b0;
        step();
        issue(3); chk1 = 3;
        step();
        req0(3, 546);
        step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        req0(4, 12); req1(5, 24);
        step(); step(); step(); step();
        req1(0, 654);
        step(); step();
        issue(7); step();
        issue(7); step();
        issue(8); step();
        req0(8, 32'h88); step();
        issue(8); chk2 = 8; step();
        step();
        req0(9, 99); step();
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            if (!wb.req0_valid_i && $urandom_range(0, 1) == 0) req0(AW'($urandom_range(0, 31)), $urandom);
            if (!wb.req1_valid_i && $urandom_range(0, 2) == 0) req1(AW'($urandom_range(0, 31)), $urandom);
            issue_rd = AW'($urandom_range(0, 31));
            issue_valid = $urandom_range(0, 2) == 0 && (!busy_m[issue_rd] || $urandom_range(0, 15) == 0);
            chk1 = $urandom_range(0, 2) == 0 ? cw_a : AW'($urandom_range(0, 31));
            chk2 = $urandom_range(0, 3) == 0 ? cw_a : AW'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; wb.req0_valid_i = 1'b0; wb.req1_valid_i = 1'b0;
        step(); step(); step();
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
